// File: rtl/uart_pkg.sv
// uart_buffered shared definitions.
// Register indices, STATUS bit positions, FSM state types, oversampling constants.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK = 4'(OVERSAMPLE / 2 - 1);

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV = 2'd2;
  localparam logic [1:0] REG_IE = 2'd3;

  localparam int ST_TX_FULL = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_RX_FULL = 3;
  localparam int ST_TX_BUSY = 4;
  localparam int ST_OVERRUN = 5;
  localparam int ST_FRAME = 6;
  localparam int ST_PARITY = 7;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO, pointers carry an extra wrap bit.
// Ports: clk_i, rst_i (sync, high), push_i/din_i, pop_i/dout_o, full_o, empty_o.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o = (wptr_q[AW] != rptr_q[AW]) &&
                  (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout_o = mem_q[rptr_q[AW-1:0]];

  // a pop frees a slot, so push into a full FIFO is fine that cycle
  assign do_pop = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign wptr_d = wptr_q + {{AW{1'b0}}, do_push};
  assign rptr_d = rptr_q + {{AW{1'b0}}, do_pop};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/uart_buffered.sv
// uart_buffered: bus UART, 16x baud generator, TX/RX FIFOs, flags, irq.
// Ports: clock, reset (sync, high), uart_sel/wr/rd/addr/wdata_mem/uart_data bus,
// rx_bit, tx_bit serial, uart_irq. Macro UART_PARITY_EN adds even parity.
module uart_buffered
  import uart_pkg::*;
#(
  parameter int          DATA_BITS   = 8,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_sel,
  input  logic        uart_wr_enable,
  input  logic        uart_rd_enable,
  input  logic [3:0]  uart_addr,
  input  logic [31:0] wdata_mem,
  output logic [31:0] uart_data,
  input  logic        rx_bit,
  output logic        tx_bit,
  output logic        uart_irq
);

`ifdef UART_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  logic [1:0] reg_idx;
  logic wr_data, wr_status, wr_div, wr_ie;
  logic unused_bits;

  assign reg_idx = uart_addr[3:2];
  assign wr_data = uart_sel & uart_wr_enable & (reg_idx == REG_DATA);
  assign wr_status = uart_sel & uart_wr_enable & (reg_idx == REG_STATUS);
  assign wr_div = uart_sel & uart_wr_enable & (reg_idx == REG_DIV);
  assign wr_ie = uart_sel & uart_wr_enable & (reg_idx == REG_IE);
  assign unused_bits = ^{uart_addr[1:0], wdata_mem};

  // baud tick generator
  logic [DIV_WIDTH-1:0] div_q, bcnt_q;
  logic tick;

  assign tick = (bcnt_q == div_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= DIV_WIDTH'(DEFAULT_DIV);
      bcnt_q <= '0;
    end else begin
      if (wr_div) div_q <= wdata_mem[DIV_WIDTH-1:0];
      if (wr_div || tick) bcnt_q <= '0;
      else bcnt_q <= bcnt_q + 1'b1;
    end
  end

  // FIFOs
  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] tx_dout, rx_dout, rsh_q;

  assign tx_push = wr_data & ~tx_full;
  assign rx_pop = uart_sel & uart_rd_enable &
                  (reg_idx == REG_DATA) & ~rx_empty;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(clock),
    .rst_i(reset),
    .push_i(tx_push),
    .pop_i(tx_pop),
    .din_i(wdata_mem[DATA_BITS-1:0]),
    .dout_o(tx_dout),
    .full_o(tx_full),
    .empty_o(tx_empty)
  );

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(clock),
    .rst_i(reset),
    .push_i(rx_push),
    .pop_i(rx_pop),
    .din_i(rsh_q),
    .dout_o(rx_dout),
    .full_o(rx_full),
    .empty_o(rx_empty)
  );

  // TX FSM
  tx_state_e tx_q, tx_d;
  logic [3:0] ttc_q, ttc_d;
  logic [2:0] tbi_q, tbi_d;
  logic [DATA_BITS-1:0] tsh_q, tsh_d;
  logic tpar_q, tpar_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_q <= TX_IDLE;
      ttc_q <= '0;
      tbi_q <= '0;
      tsh_q <= '0;
      tpar_q <= 1'b0;
    end else begin
      tx_q <= tx_d;
      ttc_q <= ttc_d;
      tbi_q <= tbi_d;
      tsh_q <= tsh_d;
      tpar_q <= tpar_d;
    end
  end

  always_comb begin
    tx_d = tx_q;
    ttc_d = ttc_q;
    tbi_d = tbi_q;
    tsh_d = tsh_q;
    tpar_d = tpar_q;
    tx_pop = 1'b0;
    unique case (tx_q)
      TX_IDLE: begin
        if (!tx_empty && tick) begin
          tx_pop = 1'b1;
          tsh_d = tx_dout;
          tpar_d = ^tx_dout;
          ttc_d = '0;
          tx_d = TX_START;
        end
      end
      TX_START: begin
        if (tick) begin
          ttc_d = ttc_q + 4'd1;
          if (ttc_q == LAST_TICK) begin
            tbi_d = '0;
            tx_d = TX_DATA;
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          ttc_d = ttc_q + 4'd1;
          if (ttc_q == LAST_TICK) begin
            tsh_d = tsh_q >> 1;
            tbi_d = tbi_q + 3'd1;
            if (tbi_q == LAST_IDX) begin
              if (PAR_EN) tx_d = TX_PARITY;
              else tx_d = TX_STOP;
            end
          end
        end
      end
      TX_PARITY: begin
        if (tick) begin
          ttc_d = ttc_q + 4'd1;
          if (ttc_q == LAST_TICK) tx_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tick) begin
          ttc_d = ttc_q + 4'd1;
          if (ttc_q == LAST_TICK) begin
            // chain straight into the next start bit
            if (!tx_empty) begin
              tx_pop = 1'b1;
              tsh_d = tx_dout;
              tpar_d = ^tx_dout;
              tx_d = TX_START;
            end else begin
              tx_d = TX_IDLE;
            end
          end
        end
      end
      default: tx_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_bit = 1'b1;
    unique case (tx_q)
      TX_START: tx_bit = 1'b0;
      TX_DATA: tx_bit = tsh_q[0];
      TX_PARITY: tx_bit = tpar_q;
      default: tx_bit = 1'b1;
    endcase
  end

  // RX synchroniser and FSM
  logic rx_s1_q, rx_s2_q;
  rx_state_e rx_q, rx_d;
  logic [3:0] rtc_q, rtc_d;
  logic [2:0] rbi_q, rbi_d;
  logic [DATA_BITS-1:0] rsh_d;
  logic set_ovr, set_frm, set_par;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_q <= RX_IDLE;
      rtc_q <= '0;
      rbi_q <= '0;
      rsh_q <= '0;
    end else begin
      rx_s1_q <= rx_bit;
      rx_s2_q <= rx_s1_q;
      rx_q <= rx_d;
      rtc_q <= rtc_d;
      rbi_q <= rbi_d;
      rsh_q <= rsh_d;
    end
  end

  always_comb begin
    rx_d = rx_q;
    rtc_d = rtc_q;
    rbi_d = rbi_q;
    rsh_d = rsh_q;
    rx_push = 1'b0;
    set_ovr = 1'b0;
    set_frm = 1'b0;
    set_par = 1'b0;
    unique case (rx_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          rtc_d = '0;
          rx_d = RX_START;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rtc_q == MID_TICK) begin
            // line back high at mid-start: treat as glitch
            if (rx_s2_q) begin
              rx_d = RX_IDLE;
            end else begin
              rtc_d = '0;
              rbi_d = '0;
              rx_d = RX_DATA;
            end
          end else begin
            rtc_d = rtc_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          rtc_d = rtc_q + 4'd1;
          if (rtc_q == LAST_TICK) begin
            rsh_d = {rx_s2_q, rsh_q[DATA_BITS-1:1]};
            rbi_d = rbi_q + 3'd1;
            if (rbi_q == LAST_IDX) begin
              if (PAR_EN) rx_d = RX_PARITY;
              else rx_d = RX_STOP;
            end
          end
        end
      end
      RX_PARITY: begin
        if (tick) begin
          rtc_d = rtc_q + 4'd1;
          if (rtc_q == LAST_TICK) begin
            set_par = (^rsh_q) != rx_s2_q;
            rx_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tick && (rtc_q == LAST_TICK)) begin
          rx_d = RX_IDLE;
          if (!rx_s2_q) set_frm = 1'b1;
          else if (rx_full) set_ovr = 1'b1;
          else rx_push = 1'b1;
        end else if (tick) begin
          rtc_d = rtc_q + 4'd1;
        end
      end
      default: rx_d = RX_IDLE;
    endcase
  end

  // sticky flags, IE, irq
  logic ovr_q, frm_q, par_q;
  logic [1:0] ie_q;
  logic irq_q;
  logic [2:0] clr;

  assign clr = wr_status ? wdata_mem[7:5] : 3'b000;

  always_ff @(posedge clock) begin
    if (reset) begin
      ovr_q <= 1'b0;
      frm_q <= 1'b0;
      par_q <= 1'b0;
      ie_q <= 2'b00;
      irq_q <= 1'b0;
    end else begin
      ovr_q <= set_ovr | (ovr_q & ~clr[0]);
      frm_q <= set_frm | (frm_q & ~clr[1]);
      par_q <= (PAR_EN & set_par) | (par_q & ~clr[2]);
      if (wr_ie) ie_q <= wdata_mem[1:0];
      irq_q <= (ie_q[0] & ~rx_empty) | (ie_q[1] & tx_empty);
    end
  end

  assign uart_irq = irq_q;

  logic [7:0] status;

  always_comb begin
    status = '0;
    status[ST_TX_FULL] = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL] = rx_full;
    status[ST_TX_BUSY] = (tx_q != TX_IDLE);
    status[ST_OVERRUN] = ovr_q;
    status[ST_FRAME] = frm_q;
    status[ST_PARITY] = par_q;
  end

  always_comb begin
    uart_data = '0;
    unique case (reg_idx)
      REG_DATA: uart_data[DATA_BITS-1:0] = rx_dout;
      REG_STATUS: uart_data[7:0] = status;
      REG_DIV: uart_data[DIV_WIDTH-1:0] = div_q;
      REG_IE: uart_data[1:0] = ie_q;
      default: uart_data = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_buffered.sv
// tb_uart_buffered: randomized checks of uart_buffered against a queue model.
// Covers TX waveform, loopback, RX overrun, glitch/frame error, irq, TX drop.
module tb_uart_buffered;

  logic clock = 1'b0;
  logic reset;
  logic uart_sel, uart_wr_enable, uart_rd_enable;
  logic [3:0] uart_addr;
  logic [31:0] wdata_mem, uart_data;
  logic rx_bit, tx_bit, uart_irq;
  logic loop, rx_drv;

  int n_checks = 0;
  int n_fail = 0;
  int div = 0;

  logic [7:0] exp_q[$];
  bit m_ovr, m_frm, m_par;

  assign rx_bit = loop ? tx_bit : rx_drv;

  always #5 clock = ~clock;

  uart_buffered dut (
    .clock(clock),
    .reset(reset),
    .uart_sel(uart_sel),
    .uart_wr_enable(uart_wr_enable),
    .uart_rd_enable(uart_rd_enable),
    .uart_addr(uart_addr),
    .wdata_mem(wdata_mem),
    .uart_data(uart_data),
    .rx_bit(rx_bit),
    .tx_bit(tx_bit),
    .uart_irq(uart_irq)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] r, input logic [31:0] d);
    @(negedge clock);
    uart_sel = 1'b1;
    uart_wr_enable = 1'b1;
    uart_addr = {r, 2'b00};
    wdata_mem = d;
    @(negedge clock);
    uart_sel = 1'b0;
    uart_wr_enable = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] r, output logic [31:0] d);
    @(negedge clock);
    uart_sel = 1'b1;
    uart_rd_enable = 1'b1;
    uart_addr = {r, 2'b00};
    #1 d = uart_data;
    @(negedge clock);
    uart_sel = 1'b0;
    uart_rd_enable = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    loop = 1'b0;
    rx_drv = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    div = 0;
    exp_q.delete();
    m_ovr = 0;
    m_frm = 0;
    m_par = 0;
  endtask

  task automatic set_div(input int d);
    bus_wr(2'd2, 32'(d));
    div = d;
  endtask

  // model: what the RX FIFO should hold after a good frame
  function automatic void m_rx(input logic [7:0] b);
    if (exp_q.size() < 8) exp_q.push_back(b);
    else m_ovr = 1;
  endfunction

  // status expected while both FSMs are idle
  function automatic logic [31:0] exp_status();
    logic [7:0] s;
    s = {m_par, m_frm, m_ovr, 1'b0, exp_q.size() == 8,
         exp_q.size() == 0, 1'b1, 1'b0};
    return {24'h0, s};
  endfunction

  task automatic chk_status(input string tag);
    logic [31:0] d;
    bus_rd(2'd1, d);
    check(tag, d, exp_status());
  endtask

  task automatic drain(input string tag);
    logic [31:0] d;
    while (exp_q.size() > 0) begin
      bus_rd(2'd0, d);
      check(tag, d, {24'h0, exp_q.pop_front()});
    end
  endtask

  // stop_ticks==0 means good stop; else stop held low for that many ticks
  task automatic send_frame(input logic [7:0] d, input bit par_bad,
                            input int stop_ticks);
    int bc;
    bc = 16 * (div + 1);
    rx_drv = 1'b0;
    repeat (bc) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (bc) @(negedge clock);
    end
`ifdef UART_PARITY_EN
    rx_drv = (^d) ^ par_bad;
    repeat (bc) @(negedge clock);
`else
    if (par_bad) rx_drv = 1'b1;
`endif
    if (stop_ticks != 0) begin
      rx_drv = 1'b0;
      repeat (stop_ticks * (div + 1)) @(negedge clock);
    end
    rx_drv = 1'b1;
    repeat (bc) @(negedge clock);
  endtask

  int frame_bits;
  logic [31:0] d;
  logic [9:0] frame;
  logic [7:0] b;
  bit found, seen;
  int n;

  initial begin
    frame_bits = 10;
`ifdef UART_PARITY_EN
    frame_bits = 11;
`endif
    reset = 1'b1;
    uart_sel = 0;
    uart_wr_enable = 0;
    uart_rd_enable = 0;
    uart_addr = 0;
    wdata_mem = 0;
    loop = 0;
    rx_drv = 1;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // reset state
    check("rst_tx_bit", tx_bit, 1);
    check("rst_irq", uart_irq, 0);
    chk_status("rst_status");
    bus_rd(2'd2, d);
    check("rst_div", d, 0);
    bus_rd(2'd3, d);
    check("rst_ie", d, 0);

    // TX waveform of 0x55 at DIV=0
    bus_wr(2'd0, 32'h55);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clock);
      if (!tx_bit) found = 1;
    end
    check("tx_start_seen", found, 1);
    frame = {1'b1, 8'h55, 1'b0};
    for (int bi = 0; bi < 10; bi++) begin
      logic [15:0] s;
      logic fb;
      fb = frame[bi];
      for (int k = 0; k < 16; k++) begin
        if (!(bi == 0 && k == 0)) @(negedge clock);
        s[k] = tx_bit;
      end
      check($sformatf("tx_wave_bit%0d", bi), s, {16{fb}});
      if (frame_bits == 11 && bi == 8) begin
        for (int k = 0; k < 16; k++) @(negedge clock);
      end
    end
    repeat (2) @(negedge clock);
    check("tx_idle_high", tx_bit, 1);
    chk_status("tx_done_status");

    // loopback A3, 0F
    do_reset();
    set_div(3);
    loop = 1'b1;
    bus_wr(2'd0, 32'hA3);
    bus_wr(2'd0, 32'h0F);
    m_rx(8'hA3);
    m_rx(8'h0F);
    repeat (2 * frame_bits * 16 * 4 + 200) @(negedge clock);
    chk_status("loop_status");
    drain("loop_data");
    chk_status("loop_empty");

    // randomized loopback
    for (int t = 0; t < 3; t++) begin
      do_reset();
      set_div(int'($urandom_range(0, 2)));
      loop = 1'b1;
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        bus_wr(2'd0, {24'h0, b});
        m_rx(b);
      end
      repeat (n * frame_bits * 16 * (div + 1) + 200) @(negedge clock);
      chk_status($sformatf("rnd%0d_status", t));
      drain($sformatf("rnd%0d_data", t));
    end

    // RX overrun: 9 frames without reading
    do_reset();
    set_div(1);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      send_frame(b, 0, 0);
      m_rx(b);
    end
    repeat (20) @(negedge clock);
    chk_status("ovr_status");
    drain("ovr_data");
    bus_wr(2'd1, 32'h20);
    m_ovr = 0;
    chk_status("ovr_cleared");

    // glitch then frame error
    set_div(2);
    rx_drv = 1'b0;
    repeat (4 * (div + 1)) @(negedge clock);
    rx_drv = 1'b1;
    repeat (2 * 16 * (div + 1)) @(negedge clock);
    chk_status("glitch_status");
    send_frame(8'h5A, 0, 12);
    m_frm = 1;
    repeat (50) @(negedge clock);
    chk_status("frame_err_status");
    bus_wr(2'd1, 32'h40);
    m_frm = 0;
    chk_status("frame_err_cleared");

    // RX interrupt timing
    do_reset();
    set_div(1);
    bus_wr(2'd3, 32'h1);
    repeat (2) @(negedge clock);
    check("irq_idle", uart_irq, 0);
    fork
      send_frame(8'hC4, 0, 0);
      begin
        seen = 0;
        uart_addr = 4'h4;
        for (int i = 0; i < 1000 && !seen; i++) begin
          @(negedge clock);
          if (!uart_data[2]) seen = 1;
        end
        check("rx_push_seen", seen, 1);
        check("irq_at_push", uart_irq, 0);
        @(negedge clock);
        check("irq_rise", uart_irq, 1);
      end
    join
    bus_rd(2'd0, d);
    check("irq_rx_data", d, 32'hC4);
    check("irq_hold", uart_irq, 1);
    @(negedge clock);
    check("irq_fall", uart_irq, 0);
    bus_wr(2'd3, 32'h2);
    @(negedge clock);
    check("tx_irq", uart_irq, 1);
    bus_wr(2'd3, 32'h0);

    // TX overflow: 9 writes, no ticks, then drain via loopback
    set_div(32'hFFFF);
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      bus_wr(2'd0, {24'h0, b});
      if (i < 8) m_rx(b);
    end
    bus_rd(2'd1, d);
    check("tx_full_status", d, 32'h05);
    loop = 1'b1;
    set_div(0);
    repeat (8 * frame_bits * 16 + 200) @(negedge clock);
    chk_status("tx_drop_status");
    drain("tx_drop_data");
    chk_status("tx_drop_empty");

`ifdef UART_PARITY_EN
    // bad parity still delivers the byte
    do_reset();
    set_div(1);
    send_frame(8'h07, 1, 0);
    m_rx(8'h07);
    m_par = 1;
    repeat (20) @(negedge clock);
    chk_status("par_status");
    drain("par_data");
    bus_wr(2'd1, 32'h80);
    m_par = 0;
    chk_status("par_cleared");
`endif

    // reset in the middle of a TX frame
    do_reset();
    bus_wr(2'd0, 32'h3C);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clock);
      if (!tx_bit) found = 1;
    end
    check("mid_tx_start", found, 1);
    repeat (30) @(negedge clock);
    bus_rd(2'd1, d);
    check("mid_tx_busy", d[4], 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_tx_bit", tx_bit, 1);
    reset = 1'b0;
    exp_q.delete();
    m_ovr = 0;
    m_frm = 0;
    m_par = 0;
    chk_status("mid_rst_status");
    check("mid_rst_irq", uart_irq, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_buffered.md
Name: uart_buffered

Overview:
Parametrised successor to the memory-mapped uart. It adds a programmable 16x-oversampled baud generator, TX and RX FIFOs, sticky error flags and an interrupt output. It sits on the data-memory bus, selected by uart_sel with a word address on uart_addr. Serial pins are tx_bit and rx_bit.

Parameters:
DATA_BITS, 8, payload bits per frame (5..8), sent LSB first
FIFO_DEPTH, 8, entries per FIFO (power of two, >=2)
DIV_WIDTH, 16, width of the baud divisor register
DEFAULT_DIV, 0, divisor value loaded at reset

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
uart_sel  input  1  bus select for this block
uart_wr_enable  input  1  write strobe, qualified by uart_sel
uart_rd_enable  input  1  read strobe, qualified by uart_sel; pops RX FIFO when reading DATA
uart_addr  input  4  byte address; [3:2] selects the register
wdata_mem  input  32  write data
uart_data  output  32  read data, combinational from uart_addr
rx_bit  input  1  serial input, asynchronous
tx_bit  output  1  serial output, idle high
uart_irq  output  1  level interrupt

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- Register map (uart_addr[3:2]):
  - 0 DATA: write pushes wdata_mem[DATA_BITS-1:0] to TX FIFO; read returns RX head, zero-extended.
  - 1 STATUS: [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full, [4] tx_busy, [5] overrun, [6] frame_err, [7] parity_err. Writing 1 to bits 7:5 clears them.
  - 2 DIV: [DIV_WIDTH-1:0] divisor.
  - 3 IE: [0] rx_ie, [1] tx_ie.
  - Unused read bits return 0.
- Reset values: tx_bit=1, uart_irq=0, FIFOs empty, flags 0, DIV=DEFAULT_DIV, IE=0, both FSMs IDLE.
- Baud tick: counter runs 0..DIV and pulses a tick every DIV+1 clocks. A DIV write clears the counter the same cycle. One bit time = 16 ticks.
- DATA write while tx_full: dropped, no flag raised.
- RX pop: only when uart_sel & uart_rd_enable & DATA & !rx_empty. Popping an empty FIFO has no effect.
- FIFOs: simultaneous push and pop are both honoured. Count is unchanged, and wrap-around uses pointers with an extra MSB.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: when !tx_empty, pop the byte and enter START on the next tick boundary.
  - START drives 0, DATA drives each bit LSB first, STOP drives 1; each lasts 16 ticks.
  - tx_busy=1 outside IDLE.
  - Back-to-back bytes: STOP goes straight to START, with no extra idle.
- RX sync: rx_bit passes through a 2-flop synchroniser (2-cycle latency).
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a low synchronised input enters START with the tick count cleared.
  - START: sample at tick 7; if high, it was a glitch, so return to IDLE.
  - DATA: sample each bit at mid-bit, every 16 ticks.
  - STOP: sample mid-bit. If 0, set frame_err and discard the byte. Else push; if rx_full, set overrun and drop the byte (FIFO contents unchanged). The FSM returns to IDLE at the stop mid-point to allow re-sync.
- Flags: sticky until cleared. A clear and a set in the same cycle leave the flag set.
- uart_irq = (rx_ie & !rx_empty) | (tx_ie & tx_empty), registered (1-cycle latency).
- Reset mid-frame: tx_bit returns high next cycle, and any partial RX byte is lost.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined: a PARITY state sits between DATA and STOP in both FSMs, using even parity over DATA_BITS. A received parity mismatch sets parity_err and the byte is still pushed.
- Undefined: there is no PARITY state, and STATUS[7] reads 0.

Decomposition:
- uart_pkg: register index localparams (REG_DATA/STATUS/DIV/IE), STATUS bit positions, TX/RX state enum typedefs, OVERSAMPLE=16.
- Sub-module uart_fifo: parametrised synchronous FIFO with push, pop, dout, full, empty. It is instantiated twice, once for TX and once for RX.

Test Plan:
1. DIV=0, write DATA=0x55 -> tx_bit: 16 clocks low, then bits 1,0,1,0,1,0,1,0 at 16 clocks each, then 16 high. Total 160 clocks; tx_empty=1 afterwards.
2. Loopback tx_bit->rx_bit, DIV=3, write 0xA3 then 0x0F -> after 2 frames rx_empty=0; two DATA reads return 0x000000A3 then 0x0000000F, then rx_empty=1.
3. Drive 9 valid frames into rx_bit without reading -> rx_full=1, overrun=1, and 8 reads return the first 8 bytes in order. Writing STATUS=0x20 clears overrun.
4. Pulse rx_bit low for 4 bit-ticks (under half a bit) -> no byte, no flag. Then send a frame with stop bit=0 -> frame_err=1 and rx_empty stays 1.
5. IE=1, receive one byte -> uart_irq rises one cycle after the push and falls one cycle after the pop. Push 9 bytes to TX -> the 9th is dropped and tx_full=1.
6. With UART_PARITY_EN, send 0x07 with parity bit 0 -> byte 0x07 is received and parity_err=1. Assert reset mid-TX -> tx_bit=1 on the next cycle and all STATUS bits equal reset values.
